k_and_s_control_unit: RTL



---
 rtl/k_and_s_control_unit.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/k_and_s_control_unit.sv
// K&S processor control unit: multi-cycle fetch/decode/execute FSM that drives
// the datapath control inputs, the RAM write strobe and the halt indication.

package k_and_s_pkg;

  typedef enum logic [3:0] {
    I_NOP    = 4'd0,
    I_LOAD   = 4'd1,
    I_STORE  = 4'd2,
    I_MOVE   = 4'd3,
    I_ADD    = 4'd4,
    I_SUB    = 4'd5,
    I_AND    = 4'd6,
    I_OR     = 4'd7,
    I_BRANCH = 4'd8,
    I_BZERO  = 4'd9,
    I_BNZERO = 4'd10,
    I_BNEG   = 4'd11,
    I_BNNEG  = 4'd12,
    I_BOV    = 4'd13,
    I_BNOV   = 4'd14,
    I_HALT   = 4'd15
  } decoded_instruction_type;

  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_LOAD   = 4'd3,
    S_STORE  = 4'd4,
    S_MOVE   = 4'd5,
    S_ALU    = 4'd6,
    S_BR     = 4'd7,
    S_HALT   = 4'd8
  } cu_state_t;

  typedef enum logic [2:0] {
    BC_ALWAYS = 3'd0,
    BC_ZERO   = 3'd1,
    BC_NZERO  = 3'd2,
    BC_NEG    = 3'd3,
    BC_NNEG   = 3'd4,
    BC_OV     = 3'd5,
    BC_NOV    = 3'd6
  } br_cond_t;

  // Debug view: FSM state, wait counter and the raw flag inputs
  // {signed_overflow, unsigned_overflow, neg_op, zero_op}.
  typedef struct packed {
    cu_state_t   state;
    logic [2:0]  wait_cnt;
    logic [3:0]  flags;
  } cu_dbg_t;

endpackage

module k_and_s_control_unit
  import k_and_s_pkg::*;
#(
  parameter int RAM_LATENCY = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  decoded_instruction_type decoded_instruction,
  input  logic                    zero_op,
  input  logic                    neg_op,
  input  logic                    unsigned_overflow,
  input  logic                    signed_overflow,
  output logic                    branch,
  output logic                    pc_enable,
  output logic                    ir_enable,
  output logic                    addr_sel,
  output logic                    c_sel,
  output logic [1:0]              operation,
  output logic                    write_reg_enable,
  output logic                    flags_reg_enable,
  output logic                    ram_write_enable,
  output logic                    halt,
  output cu_dbg_t                 dbg_o
);

  localparam logic [2:0] LAST_WAIT = 3'(RAM_LATENCY);

  cu_state_t  state_q, state_d;
  logic [2:0] wait_q, wait_d;
  logic [1:0] op_q, op_d;
  br_cond_t   brc_q, brc_d;
  logic       br_taken;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_INIT;
      wait_q  <= 3'd0;
      op_q    <= 2'b00;
      brc_q   <= BC_ALWAYS;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      op_q    <= op_d;
      brc_q   <= brc_d;
    end
  end

  // The ALU op and branch condition are captured in DECODE so that the
  // execute-state outputs depend only on registered state.
  always_comb begin
    br_taken = 1'b0;
    case (brc_q)
      BC_ALWAYS: br_taken = 1'b1;
      BC_ZERO:   br_taken = zero_op;
      BC_NZERO:  br_taken = ~zero_op;
      BC_NEG:    br_taken = neg_op;
      BC_NNEG:   br_taken = ~neg_op;
      BC_OV:     br_taken = unsigned_overflow;
      BC_NOV:    br_taken = ~unsigned_overflow;
      default:   br_taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d          = state_q;
    wait_d           = wait_q;
    op_d             = op_q;
    brc_d            = brc_q;
    branch           = 1'b0;
    pc_enable        = 1'b0;
    ir_enable        = 1'b0;
    addr_sel         = 1'b0;
    c_sel            = 1'b0;
    operation        = 2'b00;
    write_reg_enable = 1'b0;
    flags_reg_enable = 1'b0;
    ram_write_enable = 1'b0;
    halt             = 1'b0;

    case (state_q)
      S_INIT: begin
        addr_sel = 1'b1;
        wait_d   = 3'd0;
        state_d  = S_FETCH;
      end

      S_FETCH: begin
        addr_sel = 1'b1;
        if (wait_q == LAST_WAIT) begin
          ir_enable = 1'b1;
          pc_enable = 1'b1;
          wait_d    = 3'd0;
          state_d   = S_DECODE;
        end else begin
          wait_d = wait_q + 3'd1;
        end
      end

      S_DECODE: begin
        case (decoded_instruction)
          I_LOAD:   state_d = S_LOAD;
          I_STORE:  state_d = S_STORE;
          I_MOVE:   state_d = S_MOVE;
          I_ADD:    begin op_d = 2'b00; state_d = S_ALU; end
          I_AND:    begin op_d = 2'b01; state_d = S_ALU; end
          I_OR:     begin op_d = 2'b10; state_d = S_ALU; end
          I_SUB:    begin op_d = 2'b11; state_d = S_ALU; end
          I_BRANCH: begin brc_d = BC_ALWAYS; state_d = S_BR; end
          I_BZERO:  begin brc_d = BC_ZERO;   state_d = S_BR; end
          I_BNZERO: begin brc_d = BC_NZERO;  state_d = S_BR; end
          I_BNEG:   begin brc_d = BC_NEG;    state_d = S_BR; end
          I_BNNEG:  begin brc_d = BC_NNEG;   state_d = S_BR; end
          I_BOV:    begin brc_d = BC_OV;     state_d = S_BR; end
          I_BNOV:   begin brc_d = BC_NOV;    state_d = S_BR; end
          I_HALT:   state_d = S_HALT;
          default:  state_d = S_FETCH;
        endcase
      end

      S_LOAD: begin
        c_sel = 1'b1;
        if (wait_q == LAST_WAIT) begin
          write_reg_enable = 1'b1;
          wait_d           = 3'd0;
          state_d          = S_FETCH;
        end else begin
          wait_d = wait_q + 3'd1;
        end
      end

      S_STORE: begin
        ram_write_enable = 1'b1;
        state_d          = S_FETCH;
      end

      // MOVE is routed through the ALU as a|a without touching the flags.
      S_MOVE: begin
        operation        = 2'b10;
        write_reg_enable = 1'b1;
        state_d          = S_FETCH;
      end

      S_ALU: begin
        operation        = op_q;
        write_reg_enable = 1'b1;
        flags_reg_enable = 1'b1;
        state_d          = S_FETCH;
      end

      // A not-taken branch does nothing: PC already advanced during FETCH.
      S_BR: begin
        if (br_taken) begin
          branch    = 1'b1;
          pc_enable = 1'b1;
        end
        state_d = S_FETCH;
      end

      S_HALT: begin
        halt     = 1'b1;
        addr_sel = 1'b1;
      end

      default: state_d = S_INIT;
    endcase
  end

  assign dbg_o = '{state:    state_q,
                   wait_cnt: wait_q,
                   flags:    {signed_overflow, unsigned_overflow, neg_op, zero_op}};

endmodule
